// File: rtl/gf16_reduce_acc.sv
// Two-stage GF(2^16) reducer for 31-bit carry-less products with optional
// XOR accumulation of a burst into a single 16-bit result.
module gf16_reduce_acc #(
  parameter logic [15:0] POLY = 16'h002B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [30:0] in_prod,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data
);

  // The upper byte must be clear so both fold widths below are exact.
  if (POLY[15:8] != 8'h00) begin : g_poly_check
    $error("gf16_reduce_acc: POLY[15:8] must be zero");
  end

  function automatic logic [21:0] fold_hi(input logic [14:0] v);
    logic [21:0] f;
    f = '0;
    for (int k = 0; k < 15; k++) begin
      if (v[k]) f = f ^ ({6'h00, POLY} << k);
    end
    return f;
  endfunction

  function automatic logic [15:0] fold_lo(input logic [5:0] v);
    logic [15:0] f;
    f = '0;
    for (int k = 0; k < 6; k++) begin
      if (v[k]) f = f ^ (POLY << k);
    end
    return f;
  endfunction

  logic [21:0] t_d, t_q;
  logic        s1_valid_d, s1_valid_q;
  logic        s1_last_d, s1_last_q;
  logic [15:0] acc_d, acc_q;
  logic        out_valid_d, out_valid_q;
  logic [15:0] out_data_d, out_data_q;

  logic        s1_advance;
  logic        in_fire;
  logic [15:0] r;
  logic [15:0] a;

  // Non-last beats only touch acc, so only a last beat can be held by a full output.
  always_comb begin
    s1_advance = s1_valid_q && (!s1_last_q || !out_valid_q || out_ready);
    in_ready   = rst_n && (!s1_valid_q || s1_advance);
    in_fire    = in_valid && in_ready;
    r          = t_q[15:0] ^ fold_lo(t_q[21:16]);
    a          = acc_q ^ r;

    t_d         = t_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (s1_advance) begin
      s1_valid_d = 1'b0;
      if (s1_last_q) begin
        out_valid_d = 1'b1;
        out_data_d  = a;
        acc_d       = '0;
      end else begin
        acc_d = a;
      end
    end

    if (in_fire) begin
      t_d        = {6'h00, in_prod[15:0]} ^ fold_hi(in_prod[30:16]);
      s1_last_d  = in_last;
      s1_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q         <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      t_q         <= t_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_gf16_reduce_acc.sv
// Self-checking bench for gf16_reduce_acc: two instances (default POLY and 0x001B)
// share stimulus; a per-instance scoreboard built on bit-serial reduction checks every output.
module tb_gf16_reduce_acc;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [30:0] in_prod;
  logic        in_last;
  logic        out_ready;

  logic        in_ready0, out_valid0;
  logic [15:0] out_data0;
  logic        in_ready1, out_valid1;
  logic [15:0] out_data1;

  int total  = 0;
  int passed = 0;

  logic [15:0] acc0, acc1;
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic        saw_stall = 1'b0;

  gf16_reduce_acc #(.POLY(16'h002B)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready0), .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0)
  );

  gf16_reduce_acc #(.POLY(16'h001B)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready1), .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Long division of the product by x^16 + poly, one quotient bit at a time.
  function automatic logic [15:0] refReduce(input logic [30:0] p, input logic [15:0] poly);
    logic [31:0] rem;
    logic [31:0] modulus;
    rem = {1'b0, p};
    modulus = {15'h0000, 1'b1, poly};
    for (int i = 30; i >= 16; i--) begin
      if (rem[i]) rem = rem ^ (modulus << (i - 16));
    end
    return rem[15:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard: sampled on the falling edge, when all handshake signals are settled.
  always @(negedge clk) begin
    if (!rst_n) begin
      acc0 = '0;
      acc1 = '0;
      q0.delete();
      q1.delete();
      checkOutput("rst_out_valid0", {31'b0, out_valid0}, 32'd0);
      checkOutput("rst_out_valid1", {31'b0, out_valid1}, 32'd0);
      checkOutput("rst_out_data0", {16'b0, out_data0}, 32'd0);
      checkOutput("rst_in_ready0", {31'b0, in_ready0}, 32'd0);
    end else begin
      if (!in_ready0) begin
        saw_stall = 1'b1;
        checkOutput("ready_low_cause", {31'b0, out_valid0 && !out_ready}, 32'd1);
      end
      if (q0.size() == 0) checkOutput("spurious_out0", {31'b0, out_valid0}, 32'd0);
      else if (out_valid0) begin
        checkOutput("sb_data0", {16'b0, out_data0}, {16'b0, q0[0]});
        if (out_ready) void'(q0.pop_front());
      end
      if (q1.size() == 0) checkOutput("spurious_out1", {31'b0, out_valid1}, 32'd0);
      else if (out_valid1) begin
        checkOutput("sb_data1", {16'b0, out_data1}, {16'b0, q1[0]});
        if (out_ready) void'(q1.pop_front());
      end
      if (in_valid && in_ready0) begin
        acc0 = acc0 ^ refReduce(in_prod, 16'h002B);
        if (in_last) begin
          q0.push_back(acc0);
          acc0 = '0;
        end
      end
      if (in_valid && in_ready1) begin
        acc1 = acc1 ^ refReduce(in_prod, 16'h001B);
        if (in_last) begin
          q1.push_back(acc1);
          acc1 = '0;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [30:0] prod, input logic last, output int waited);
    in_valid = 1'b1;
    in_prod  = prod;
    in_last  = last;
    waited   = 0;
    @(negedge clk);
    while (!in_ready0 && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 50) checkOutput("accept_timeout", {31'b0, in_ready0}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic waitOutput(output int lat);
    lat = 1;
    while (!out_valid0 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid0) checkOutput("out_timeout", {31'b0, out_valid0}, 32'd1);
  endtask

  task automatic checkResult(input string name, input logic [15:0] exp0, input logic [15:0] exp1);
    int lat;
    waitOutput(lat);
    checkOutput({name, "_p2b"}, {16'b0, out_data0}, {16'b0, exp0});
    checkOutput({name, "_p1b"}, {16'b0, out_data1}, {16'b0, exp1});
    @(posedge clk);
    #1;
  endtask

  task automatic singleCheck(input string name, input logic [30:0] prod,
                             input logic [15:0] exp0, input logic [15:0] exp1);
    int waited;
    int lat;
    applyStimulus(prod, 1'b1, waited);
    waitOutput(lat);
    checkOutput({name, "_latency"}, lat, 32'd2);
    checkOutput({name, "_p2b"}, {16'b0, out_data0}, {16'b0, exp0});
    checkOutput({name, "_p1b"}, {16'b0, out_data1}, {16'b0, exp1});
    @(posedge clk);
    #1;
  endtask

  initial begin
    int waited;
    logic [3:0] pat;
    logic feed_done;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("in_ready_after_reset", {31'b0, in_ready0}, 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] single-beat reductions");
    singleCheck("single_1234", 31'h0000_1234, 16'h1234, 16'h1234);
    singleCheck("single_x16", 31'h0001_0000, 16'h002B, 16'h001B);
    singleCheck("single_x30", 31'h4000_0000, 16'hC10E, 16'hC05A);

    $display("[TB] burst accumulation");
    applyStimulus(31'h0000_1234, 1'b0, waited);
    applyStimulus(31'h0001_0000, 1'b0, waited);
    applyStimulus(31'h0000_0001, 1'b1, waited);
    checkResult("burst3", 16'h121E, 16'h122E);
    singleCheck("after_burst", 31'h0000_0005, 16'h0005, 16'h0005);

    applyStimulus(31'h4000_0000, 1'b0, waited);
    applyStimulus(31'h4000_0000, 1'b1, waited);
    checkResult("cancel", 16'h0000, 16'h0000);

    $display("[TB] back-to-back singles");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(31'(32'h0100_0000 * i + 32'h37), 1'b1, waited);
      checkOutput("b2b_no_wait", waited, 32'd0);
    end
    repeat (4) @(posedge clk);
    #1;

    $display("[TB] output backpressure");
    pat = 4'b1001;
    feed_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          applyStimulus(31'(32'h1357_9BDF ^ (32'h0F0F_1111 * (i + 1))), 1'b1, waited);
        feed_done = 1'b1;
      end
      begin
        int ph;
        ph = 0;
        while (!feed_done) begin
          out_ready = pat[ph % 4];
          ph++;
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    checkOutput("in_ready_backpressure", {31'b0, saw_stall}, 32'd1);
    checkOutput("stall_drain0", q0.size(), 32'd0);

    $display("[TB] reset mid-burst");
    applyStimulus(31'h0000_0011, 1'b0, waited);
    applyStimulus(31'h0000_0022, 1'b0, waited);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    singleCheck("post_reset", 31'h0000_0007, 16'h0007, 16'h0007);

    $display("[TB] random traffic");
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_prod   = 31'($urandom());
      in_last   = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    applyStimulus(31'h0000_0001, 1'b1, waited);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("final_drain0", q0.size(), 32'd0);
    checkOutput("final_drain1", q1.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gf16_reduce_acc.md
# gf16_reduce_acc

Downstream consumer of the 16-bit carry-less (GF(2)) Karatsuba multiplier's 31-bit product. It reduces each product modulo a fixed degree-16 irreducible polynomial to a GF(2^16) element and optionally XOR-accumulates a burst of reduced products into a single 16-bit result. It is a two-stage pipeline with valid/ready handshakes on both sides and accepts one product per cycle at full throughput.

## Interface
- `POLY`, default `16'h002B`: low 16 coefficients of the modulus; the x^16 term is implicit, so the default is x^16+x^5+x^3+x+1. `POLY[15:8]` must be 0; elaboration fails otherwise.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: product beat is valid.
- `in_ready` output 1: block can accept a beat this cycle.
- `in_prod` input 31: carry-less product, bit i is the coefficient of x^i.
- `in_last` input 1: closes the burst. A single-product reduction is a burst with `in_last`=1.
- `out_valid` output 1: `out_data` holds a completed burst result.
- `out_ready` input 1: downstream accepts `out_data`.
- `out_data` output 16: reduced (and accumulated) GF(2^16) element.

## Operation
- A beat transfers when `in_valid`&&`in_ready`. An output transfers when `out_valid`&&`out_ready`.
- fold(v): XOR of `POLY<<k` over every set bit k of v, computed purely in GF(2) (XOR only, no carries).
- Stage 1 (S1) registers:
  - t = `in_prod[15:0]` ^ fold(`in_prod[30:16]`), 22 bits wide.
  - `last` flag and `s1_valid`.
- Stage 2 (S2), combinational from S1:
  - r = t[15:0] ^ fold(t[21:16]), which always fits in 16 bits.
  - a = acc ^ r.
- When S1 advances into S2:
  - If last=0: acc <= a. No output is produced.
  - If last=1: `out_data` <= a, `out_valid` <= 1, acc <= 0.
- An S1 beat with last=0 always advances, because it only updates acc.
- An S1 beat with last=1 advances only if the output register is empty or being drained that cycle (`!out_valid || out_ready`). Otherwise S1 holds.
- S1 loads when it is empty or advancing: `in_ready` = `!s1_valid || s1_advance`. This gives back-to-back acceptance with no bubble.
- `out_data` and `out_valid` stay stable while `out_valid`&&`!out_ready`.
- Burst length is unbounded. acc carries across any number of idle or stalled cycles between beats.

## Timing
- Reset values: `in_ready`=0 while `rst_n`=0 and 1 in the first cycle after release. `out_valid`=0, `out_data`=0, acc=0, `s1_valid`=0.
- Latency: a beat accepted in cycle N with `in_last`=1 has `out_valid`=1 in cycle N+2, provided the output register was free.
- Throughput: one beat per cycle with `out_ready` held high.
- Back-to-back single bursts: one output per cycle, consecutive.
- Output backpressure:
  - Stall propagates only on last beats: S1 holds, then `in_ready`=0.
  - At most one beat is buffered in S1 and one in the output register.
  - No beat is lost or duplicated.
- Simultaneous drain and refill of the output register in the same cycle is allowed, with no bubble.
- Reset asserted mid-burst: acc, S1 and output are cleared immediately. The partial burst is discarded. The next beat starts a fresh burst.
- `in_last` is sampled only on transferring beats.

## Test plan
1. Reset, then single beats with `in_last`=1 and `out_ready`=1:
   - `in_prod`=0x0000_1234 -> `out_data`=0x1234.
   - `in_prod`=0x0001_0000 -> `out_data`=0x002B.
   - `in_prod`=0x4000_0000 (x^30) -> `out_data`=0xC10E.
   - Each output appears 2 cycles after acceptance.
2. Burst of 0x1234 (last=0), 0x0001_0000 (last=0), 0x0000_0001 (last=1) -> exactly one output, `out_data`=0x121E. A following single beat 0x0005 (last=1) -> `out_data`=0x0005, confirming acc was cleared.
3. Burst of x^30 (last=0) then x^30 (last=1) -> `out_data`=0x0000.
4. Stream of 8 single-beat products with `out_ready` toggled 1,0,0,1,… -> all 8 results emerge in order, with values unchanged while stalled. `in_ready` drops within 2 cycles of a stall. No loss or duplication.
5. Assert `rst_n`=0 after 2 beats of an open burst, release, then send 0x0007 (last=1) -> `out_data`=0x0007. `out_valid`=0 throughout reset.
6. 10k random 31-bit products with random `in_last`/`in_valid`/`out_ready` -> outputs match a bit-serial polynomial-reduction reference model, for both the default `POLY` and `POLY`=0x001B.
